// File: rtl/contadores_salida.sv
// Per-queue push counters for the four output FIFOs, with a request/valid read
// port that only answers while the fabric is idle.
module contadores_salida #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push0,
  input  logic             push1,
  input  logic             push2,
  input  logic             push3,
  input  logic             idle,
  input  logic             req,
  input  logic [1:0]       idx,
  output logic [CNT_W-1:0] data_out,
  output logic             valid_out,
  output logic             busy,
  output logic [3:0]       ovf
);

  typedef enum logic [1:0] {COUNT, PENDING, RESPOND} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       idx_q;
  logic [3:0]       push;
  logic             capture;
  logic [1:0]       cap_idx;

  assign push = {push3, push2, push1, push0};

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    cap_idx  = idx_q;
    unique case (state)
      COUNT: begin
        if (req) begin
          if (idle) begin
            capture  = 1'b1;
            cap_idx  = idx;
            state_nx = RESPOND;
          end else begin
            state_nx = PENDING;
          end
        end
      end
      PENDING: begin
        if (idle) begin
          capture  = 1'b1;
          cap_idx  = idx_q;
          state_nx = RESPOND;
        end
      end
      RESPOND: state_nx = COUNT;
      default: state_nx = COUNT;
    endcase
  end

  // valid_out/busy are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      state     <= COUNT;
      idx_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == COUNT && req && !idle)
        idx_q <= idx;
      if (capture)
        data_out <= cnt[cap_idx];
      valid_out <= (state_nx == RESPOND);
      busy      <= (state_nx != COUNT);
    end
  end

  // Saturating counters; a push at full scale sets the sticky overflow bit.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      for (int unsigned i = 0; i < 4; i++)
        cnt[i[1:0]] <= '0;
      ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (push[i[1:0]]) begin
          if (cnt[i[1:0]] == '1)
            ovf[i[1:0]] <= 1'b1;
          else
            cnt[i[1:0]] <= cnt[i[1:0]] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_contadores_salida.sv
// Randomized bench for contadores_salida against a saturating-count model.
module tb_contadores_salida;
  localparam int CNT_W = 5;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_L;
  logic [3:0]       p;
  logic             idle, req;
  logic [1:0]       idx;
  logic [CNT_W-1:0] data_out;
  logic             valid_out, busy;
  logic [3:0]       ovf;

  int         checks = 0;
  int         failures = 0;
  int         cnt_m [4];
  logic [3:0] ovf_m;

  contadores_salida #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L),
    .push0(p[0]), .push1(p[1]), .push2(p[2]), .push3(p[3]),
    .idle(idle), .req(req), .idx(idx),
    .data_out(data_out), .valid_out(valid_out), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // One clock edge; the model applies the pushes that were present at it.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (p[i]) begin
        if (cnt_m[i] == MAX) ovf_m[i] = 1'b1;
        else cnt_m[i]++;
      end
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    ovf_m = '0;
  endtask

  task automatic hard_reset();
    p = '0; req = 1'b0; idx = '0; idle = 1'b1;
    reset_L = 1'b1;
    model_clear();
    @(negedge clk);
    reset_L = 1'b0;
    cycle();
  endtask

  // Issues one read while idle; returns what the port showed one edge later.
  task automatic do_read(input logic [1:0] i, input logic [3:0] pp,
                         output logic v, output logic [CNT_W-1:0] d, output int e);
    idle = 1'b1; req = 1'b1; idx = i; p = pp;
    e = cnt_m[i];
    cycle();
    v = valid_out; d = data_out;
    req = 1'b0; p = '0;
    cycle();
  endtask

  task automatic test_reset();
    p = '0; req = 1'b0; idx = '0; idle = 1'b1;
    reset_L = 1'b1;
    model_clear();
    #2;
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data: got %0d expected 0", data_out); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    @(negedge clk);
    reset_L = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    logic v; logic [CNT_W-1:0] d; int e;
    p = 4'b0101; repeat (3) cycle();
    p = 4'b0100; repeat (4) cycle();
    p = '0;
    do_read(2'd2, 4'b0000, v, d, e);
    checks++; if (v !== 1'b1 || d !== CNT_W'(e) || e != 7) begin failures++; $display("FAIL basic_idx2: got valid=%b data=%0d expected valid=1 data=7", v, d); end
    do_read(2'd0, 4'b0000, v, d, e);
    checks++; if (v !== 1'b1 || d !== CNT_W'(e) || e != 3) begin failures++; $display("FAIL basic_idx0: got valid=%b data=%0d expected valid=1 data=3", v, d); end
  endtask

  task automatic test_pending();
    int e;
    idle = 1'b0; req = 1'b1; idx = 2'd1; p = '0;
    cycle();
    checks++; if (busy !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL pend_enter: got busy=%b valid=%b expected busy=1 valid=0", busy, valid_out); end
    idx = 2'd3; p = 4'b0010;
    repeat (4) begin
      cycle();
      checks++; if (busy !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL pend_wait: got busy=%b valid=%b expected busy=1 valid=0", busy, valid_out); end
    end
    p = '0; req = 1'b0; idle = 1'b1;
    e = cnt_m[1];
    cycle();
    checks++; if (valid_out !== 1'b1 || data_out !== CNT_W'(e) || e != 4) begin failures++; $display("FAIL pend_resp: got valid=%b data=%0d expected valid=1 data=4", valid_out, data_out); end
    cycle();
    checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL pend_done: got valid=%b busy=%b expected 0 0", valid_out, busy); end
  endtask

  task automatic test_saturation();
    logic v; logic [CNT_W-1:0] d; int e;
    p = 4'b1000; repeat (35) cycle();
    p = '0;
    checks++; if (ovf !== ovf_m || ovf_m !== 4'b1000) begin failures++; $display("FAIL sat_ovf: got %b expected 1000", ovf); end
    do_read(2'd3, 4'b0000, v, d, e);
    checks++; if (v !== 1'b1 || d !== CNT_W'(e) || e != MAX) begin failures++; $display("FAIL sat_cnt3: got %0d expected %0d", d, MAX); end
    do_read(2'd0, 4'b0000, v, d, e);
    checks++; if (v !== 1'b1 || d !== CNT_W'(e)) begin failures++; $display("FAIL sat_cnt0: got %0d expected %0d", d, e); end
  endtask

  task automatic test_simultaneous();
    logic v; logic [CNT_W-1:0] d; int e;
    hard_reset();
    p = 4'b1111; repeat (5) cycle();
    p = '0;
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), 4'b0000, v, d, e);
      checks++; if (v !== 1'b1 || d !== CNT_W'(e) || e != 5) begin failures++; $display("FAIL simul_cnt%0d: got %0d expected 5", i, d); end
    end
    do_read(2'd0, 4'b0001, v, d, e);
    checks++; if (d !== CNT_W'(e) || e != 5) begin failures++; $display("FAIL push_same_cycle: got %0d expected 5", d); end
    do_read(2'd0, 4'b0000, v, d, e);
    checks++; if (d !== CNT_W'(e) || e != 6) begin failures++; $display("FAIL push_after: got %0d expected 6", d); end
  endtask

  task automatic test_reset_mid_pending();
    logic v; logic [CNT_W-1:0] d; int e;
    p = 4'b1000; repeat (40) cycle();
    p = '0; idle = 1'b0; req = 1'b1; idx = 2'd2;
    cycle();
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstp_busy_before: got %b expected 1", busy); end
    #2;
    reset_L = 1'b1;
    model_clear();
    #1;
    checks++; if (busy !== 1'b0 || valid_out !== 1'b0) begin failures++; $display("FAIL rstp_async: got busy=%b valid=%b expected 0 0", busy, valid_out); end
    checks++; if (ovf !== 4'b0000 || data_out !== '0) begin failures++; $display("FAIL rstp_clear: got ovf=%b data=%0d expected 0000 0", ovf, data_out); end
    @(negedge clk);
    reset_L = 1'b0; idle = 1'b1;
    repeat (4) begin
      cycle();
      checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstp_no_pulse: got valid=%b busy=%b expected 0 0", valid_out, busy); end
    end
    do_read(2'd3, 4'b0000, v, d, e);
    checks++; if (d !== CNT_W'(e) || e != 0) begin failures++; $display("FAIL rstp_cnt3: got %0d expected 0", d); end
  endtask

  task automatic test_back_to_back();
    int e;
    logic ev;
    idle = 1'b1; req = 1'b1;
    e = 0;
    for (int k = 0; k < 8; k++) begin
      idx = 2'($urandom);
      p = 4'($urandom & $urandom);
      ev = ((k % 2) == 0);
      if (ev) e = cnt_m[idx];
      cycle();
      checks++; if (valid_out !== ev) begin failures++; $display("FAIL b2b_valid k=%0d: got %b expected %b", k, valid_out, ev); end
      if (ev) begin
        checks++; if (data_out !== CNT_W'(e)) begin failures++; $display("FAIL b2b_data k=%0d: got %0d expected %0d", k, data_out, e); end
      end
    end
    req = 1'b0; p = '0;
    cycle();
  endtask

  task automatic test_random();
    logic v; logic [CNT_W-1:0] d; int e;
    logic [1:0] sel;
    int n;
    hard_reset();
    for (int it = 0; it < 24; it++) begin
      p = 4'($urandom & $urandom); req = 1'b0; idle = 1'($urandom);
      repeat ($urandom_range(0, 3)) begin cycle(); p = 4'($urandom & $urandom); end
      sel = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_read(sel, 4'($urandom), v, d, e);
        checks++; if (v !== 1'b1 || d !== CNT_W'(e)) begin failures++; $display("FAIL rnd_direct it=%0d: got valid=%b data=%0d expected 1 %0d", it, v, d, e); end
      end else begin
        idle = 1'b0; req = 1'b1; idx = sel; p = 4'($urandom & $urandom);
        cycle();
        checks++; if (busy !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL rnd_pend it=%0d: got busy=%b valid=%b expected 1 0", it, busy, valid_out); end
        n = $urandom_range(0, 4);
        repeat (n) begin
          req = 1'($urandom); idx = 2'($urandom); p = 4'($urandom & $urandom);
          cycle();
          checks++; if (busy !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL rnd_hold it=%0d: got busy=%b valid=%b expected 1 0", it, busy, valid_out); end
        end
        idle = 1'b1; req = 1'($urandom); idx = 2'($urandom); p = 4'($urandom & $urandom);
        e = cnt_m[sel];
        cycle();
        checks++; if (valid_out !== 1'b1 || data_out !== CNT_W'(e)) begin failures++; $display("FAIL rnd_resp it=%0d: got valid=%b data=%0d expected 1 %0d", it, valid_out, data_out, e); end
        req = 1'b0; p = 4'($urandom & $urandom); idle = 1'($urandom);
        cycle();
        checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rnd_after it=%0d: got valid=%b busy=%b expected 0 0", it, valid_out, busy); end
      end
      checks++; if (ovf !== ovf_m) begin failures++; $display("FAIL rnd_ovf it=%0d: got %b expected %b", it, ovf, ovf_m); end
    end
    p = '0; req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_saturation();
    test_simultaneous();
    test_reset_mid_pending();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
